// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the core's AXI4-Lite masters: response codes, LSU master
// states, request payload and the alignment helpers used by LSU_AXIL_MISALIGN_CHK_EN.
package npc_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    RSP   = 3'd5
  } lsu_axil_state_e;

  typedef struct packed {
    logic                  wen;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wmask;
  } lsu_req_t;

  function automatic logic [2:0] strb_popcount(input logic [BUS_STRB_W-1:0] strb);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < BUS_STRB_W; i++) begin
      cnt = cnt + {2'b00, strb[i]};
    end
    return cnt;
  endfunction

  // Store size is inferred from how many byte lanes the LSU enabled.
  function automatic logic [1:0] size_from_strb(input logic [BUS_STRB_W-1:0] strb);
    case (strb_popcount(strb))
      3'd0, 3'd1: return SIZE_B;
      3'd2:       return SIZE_H;
      default:    return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axil_master_timeout_cnt.sv
// Wait-state watchdog shared by the bus masters: counts enabled cycles since the last
// clear and flags the cycle in which the count would reach LIMIT (LIMIT = 0 disables).
module bus_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : {CW{1'b0}};

  logic [CW-1:0] cnt_r;

  // Cycle counter, restarted on every state change of the owning master.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (LIMIT > 0)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (LIMIT > 0) && enable && (cnt_r == LAST);

endmodule

// File: rtl/lsu_axil_master.sv
// LSU data-side AXI4-Lite master: one load/store per transaction, one outstanding.
// Optional LSU_AXIL_MISALIGN_CHK_EN adds req_size and rejects misaligned accesses locally.
module lsu_axil_master
  import npc_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
`ifdef LSU_AXIL_MISALIGN_CHK_EN
  input  logic [1:0]          req_size,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  lsu_axil_state_e   state_r, state_nxt_s;
  lsu_req_t          req_r, req_nxt_s;
  logic              aw_done_r, aw_done_nxt_s;
  logic              w_done_r, w_done_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              err_r, err_nxt_s;
  logic              wait_s, tmo_s, clr_s, misalign_s;

`ifdef LSU_AXIL_MISALIGN_CHK_EN
  assign misalign_s = is_misaligned(req_addr[1:0], req_wen ? size_from_strb(req_wmask) : req_size);
`else
  assign misalign_s = 1'b0;
`endif

  assign wait_s = (state_r == RD_A) || (state_r == RD_D) || (state_r == WR_AW) || (state_r == WR_B);
  assign clr_s  = (state_nxt_s != state_r);

  bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clr_s),
    .enable (wait_s),
    .expire (tmo_s)
  );

  // Next-state logic; a completing handshake takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt_s   = state_r;
    req_nxt_s     = req_r;
    aw_done_nxt_s = aw_done_r;
    w_done_nxt_s  = w_done_r;
    rdata_nxt_s   = rdata_r;
    err_nxt_s     = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          req_nxt_s     = '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
          aw_done_nxt_s = 1'b0;
          w_done_nxt_s  = 1'b0;
          rdata_nxt_s   = {DATA_W{1'b0}};
          err_nxt_s     = misalign_s;
          if (misalign_s) begin
            state_nxt_s = RSP;
          end else begin
            state_nxt_s = req_wen ? WR_AW : RD_A;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_A: begin
        if (m_arready) begin
          state_nxt_s = RD_D;
        end else if (tmo_s) begin
          state_nxt_s = RSP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = RD_A;
        end
      end
      RD_D: begin
        if (m_rvalid) begin
          state_nxt_s = RSP;
          rdata_nxt_s = m_rdata;
          err_nxt_s   = (m_rresp != RESP_OKAY);
        end else if (tmo_s) begin
          state_nxt_s = RSP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = RD_D;
        end
      end
      WR_AW: begin
        aw_done_nxt_s = aw_done_r | m_awready;
        w_done_nxt_s  = w_done_r | m_wready;
        if (aw_done_nxt_s && w_done_nxt_s) begin
          state_nxt_s = WR_B;
        end else if (tmo_s) begin
          state_nxt_s = RSP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = WR_AW;
        end
      end
      WR_B: begin
        if (m_bvalid) begin
          state_nxt_s = RSP;
          err_nxt_s   = (m_bresp != RESP_OKAY);
        end else if (tmo_s) begin
          state_nxt_s = RSP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = WR_B;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RSP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      req_r     <= '0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      req_r     <= req_nxt_s;
      aw_done_r <= aw_done_nxt_s;
      w_done_r  <= w_done_nxt_s;
      rdata_r   <= rdata_nxt_s;
      err_r     <= err_nxt_s;
      req_ready <= (state_nxt_s == IDLE);
      rsp_valid <= (state_nxt_s == RSP);
      m_arvalid <= (state_nxt_s == RD_A);
      m_rready  <= (state_nxt_s == RD_D);
      m_awvalid <= (state_nxt_s == WR_AW) && !aw_done_nxt_s;
      m_wvalid  <= (state_nxt_s == WR_AW) && !w_done_nxt_s;
      m_bready  <= (state_nxt_s == WR_B);
    end
  end

  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign m_araddr  = req_r.addr;
  assign m_awaddr  = req_r.addr;
  assign m_wdata   = req_r.wdata;
  assign m_wstrb   = req_r.wmask;
  assign m_arprot  = 3'b000;
  assign m_awprot  = 3'b000;

endmodule
